// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the data cache controller.
// slave: the cache controller; master: the load/store stage plus memory.
interface dcache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              flush;
    logic              cpu_busy;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_write;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata,
        output cpu_busy, cpu_ready, cpu_rdata, mem_addr, mem_wdata, mem_write
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata,
        input  cpu_busy, cpu_ready, cpu_rdata, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// with one-word lines and saturating load hit/miss counters.
module dcache_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int LINES       = 8,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    dcache_ctrl_if.slave     bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int LAT_W = $clog2(MEM_LATENCY + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MEM_RD = 2'd1;
    localparam logic [1:0] MEM_WR = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]       state;
    logic [LAT_W-1:0] cnt;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_q  [0:LINES-1];
    logic [31:0]      data_q [0:LINES-1];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             accept;
    logic             last;

    assign idx      = bus.cpu_addr[IDX_W-1:0];
    assign tag      = bus.cpu_addr[ADDR_W-1:IDX_W];
    assign fill_idx = bus.mem_addr[IDX_W-1:0];
    assign fill_tag = bus.mem_addr[ADDR_W-1:IDX_W];
    assign hit      = valid[idx] && (tag_q[idx] == tag);
    assign accept   = bus.cpu_req && !bus.cpu_busy;
    assign last     = (cnt == LAT_W'(1));

    assign bus.cpu_busy  = (state != IDLE) || bus.flush;
    assign bus.cpu_ready = (state == RESP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            valid          <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            bus.cpu_rdata  <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_write  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.flush) begin
                        valid <= '0;
                    end else if (accept && bus.cpu_we) begin
                        bus.mem_addr  <= bus.cpu_addr;
                        bus.mem_wdata <= bus.cpu_wdata;
                        bus.mem_write <= 1'b1;
                        cnt           <= LAT_W'(MEM_LATENCY);
                        state         <= MEM_WR;
                    end else if (accept && hit) begin
                        bus.cpu_rdata <= data_q[idx];
                        if (hit_count != '1)
                            hit_count <= hit_count + CNT_W'(1);
                        state <= RESP;
                    end else if (accept) begin
                        if (miss_count != '1)
                            miss_count <= miss_count + CNT_W'(1);
                        bus.mem_addr <= bus.cpu_addr;
                        cnt          <= LAT_W'(MEM_LATENCY);
                        state        <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    bus.mem_write <= 1'b0;
                    if (last) begin
                        valid[fill_idx] <= 1'b1;
                        bus.cpu_rdata   <= bus.mem_rdata;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt - LAT_W'(1);
                    end
                end
                MEM_WR: begin
                    bus.mem_write <= 1'b0;
                    if (last)
                        state <= RESP;
                    else
                        cnt <= cnt - LAT_W'(1);
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Line payload needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (reset && state == IDLE && !bus.flush && bus.cpu_req
            && bus.cpu_we && hit)
            data_q[idx] <= bus.cpu_wdata;
        if (reset && state == MEM_RD && last) begin
            data_q[fill_idx] <= bus.mem_rdata;
            tag_q[fill_idx]  <= fill_tag;
        end
    end
endmodule
